// File: rtl/serial_sum_splitter_if.sv
// Valid/ready bundle for the serial sum splitter: job in (sum, known addend), result out.
// The master modport is the job producer and result consumer; the slave is the splitter.
interface serial_sum_splitter_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH:0]   sum_in;
   logic [WIDTH-1:0] opb_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff_out;
   logic             err_out;

   modport master (
      output in_valid, sum_in, opb_in, out_ready,
      input  in_ready, out_valid, diff_out, err_out
   );

   modport slave (
      input  in_valid, sum_in, opb_in, out_ready,
      output in_ready, out_valid, diff_out, err_out
   );
endinterface

// File: rtl/serial_sum_splitter.sv
// Recovers addend a = p - b from a (WIDTH+1)-bit sum p and addend b by bit-serial
// subtraction, LSB first, one bit per clock, with a single borrow flop.
module serial_sum_splitter #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_sum_splitter_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [WIDTH:0]   s_q, s_d;
   logic [WIDTH:0]   b_q, b_d;
   logic [WIDTH:0]   r_q, r_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             err_q, err_d;

   logic             dbit_s;
   logic             borrow_nxt_s;
   logic [WIDTH:0]   r_shift_s;

   // One full-subtractor step on the current LSBs of the sum and addend shifters.
   always_comb begin
      dbit_s       = s_q[0] ^ b_q[0] ^ borrow_q;
      borrow_nxt_s = (~s_q[0] & b_q[0]) | (~s_q[0] & borrow_q) | (b_q[0] & borrow_q);
      r_shift_s    = {dbit_s, r_q[WIDTH:1]};
   end

   // FSM next state and datapath next values.
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      b_d      = b_q;
      r_d      = r_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               s_d      = bus.sum_in;
               b_d      = {1'b0, bus.opb_in};
               borrow_d = 1'b0;
               cnt_d    = {CW{1'b0}};
               state_d  = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            s_d      = {1'b0, s_q[WIDTH:1]};
            b_d      = {1'b0, b_q[WIDTH:1]};
            r_d      = r_shift_s;
            borrow_d = borrow_nxt_s;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH)) begin
               // A final borrow means p < b; a set MSB means p - b does not fit in WIDTH bits.
               diff_d  = r_shift_s[WIDTH-1:0];
               err_d   = borrow_nxt_s | r_shift_s[WIDTH];
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, shifters, borrow, counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         s_q      <= {(WIDTH+1){1'b0}};
         b_q      <= {(WIDTH+1){1'b0}};
         r_q      <= {(WIDTH+1){1'b0}};
         borrow_q <= 1'b0;
         cnt_q    <= {CW{1'b0}};
         diff_q   <= {WIDTH{1'b0}};
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         b_q      <= b_d;
         r_q      <= r_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         err_q    <= err_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.diff_out  = diff_q;
   assign bus.err_out   = err_q;
endmodule

// File: tb/tb_serial_sum_splitter.sv
// Self-checking bench for serial_sum_splitter: directed vector table, backpressure,
// asynchronous reset mid-job, and random adder-model pairs.
module tb_serial_sum_splitter;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   serial_sum_splitter_if #(.WIDTH(8)) bus ();

   serial_sum_splitter #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] p;
      logic [7:0] b;
      logic [7:0] exp_diff;
      logic       exp_err;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_job(input logic [8:0] p, input logic [7:0] b, input logic [7:0] ed,
                         input logic ee, input int stall, input string nm);
      int lat;
      bit busy_ok;
      bus.in_valid = 1'b1;
      bus.sum_in   = p;
      bus.opb_in   = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.sum_in   = 9'h155;
      bus.opb_in   = 8'hAA;
      lat = 0;
      busy_ok = 1'b1;
      while (!bus.out_valid && lat < 20) begin
         if (bus.in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_latency"}, 32'(lat), 32'd9);
      repeat (stall) begin
         if (bus.in_ready || !bus.out_valid) busy_ok = 1'b0;
         @(posedge clk); #1;
      end
      chk({nm, "_busy_in_ready_low"}, {31'd0, busy_ok}, 32'd1);
      chk({nm, "_diff"}, {24'd0, bus.diff_out}, {24'd0, ed});
      chk({nm, "_err"}, {31'd0, bus.err_out}, {31'd0, ee});
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({nm, "_release"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [8:0] rp;
      logic [8:0] t9;
      int         lat;
      bit         ok;
      checks   = 0;
      failures = 0;

      vecs[0] = '{9'h0FF, 8'h01, 8'hFE, 1'b0};
      vecs[1] = '{9'h1FE, 8'hFF, 8'hFF, 1'b0};
      vecs[2] = '{9'h100, 8'h00, 8'h00, 1'b1};
      vecs[3] = '{9'h000, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{9'h1FF, 8'h00, 8'hFF, 1'b1};
      vecs[5] = '{9'h0FF, 8'hFF, 8'h00, 1'b0};
      vecs[6] = '{9'h080, 8'h81, 8'hFF, 1'b1};
      vecs[7] = '{9'h005, 8'h0A, 8'hFB, 1'b1};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.sum_in    = 9'h000;
      bus.opb_in    = 8'h00;
      bus.out_ready = 1'b0;
      #3;
      chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset_diff", {24'd0, bus.diff_out}, 32'd0);
      chk("reset_err", {31'd0, bus.err_out}, 32'd0);
      chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         do_job(vecs[i].p, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_err, i % 3, $sformatf("vec%0d", i));
      end

      // Reset asserted off-edge while bit 4 of a job is being processed.
      bus.in_valid = 1'b1;
      bus.sum_in   = 9'h0FF;
      bus.opb_in   = 8'h01;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midrst_diff", {24'd0, bus.diff_out}, 32'd0);
      chk("midrst_err", {31'd0, bus.err_out}, 32'd0);
      chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #4 rst_n = 1'b1;
      ok = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.out_valid) ok = 1'b0;
      end
      chk("midrst_job_discarded", {31'd0, ok}, 32'd1);
      do_job(9'h0FF, 8'h01, 8'hFE, 1'b0, 0, "post_reset");

      // Backpressure: DONE held while inputs toggle.
      bus.in_valid = 1'b1;
      bus.sum_in   = 9'h1FE;
      bus.opb_in   = 8'hFF;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_latency", 32'(lat), 32'd9);
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = ~bus.in_valid;
         bus.sum_in   = 9'(k * 37 + 3);
         bus.opb_in   = 8'(k * 11);
         @(posedge clk); #1;
         chk($sformatf("bp_hold%0d", k), {22'd0, bus.out_valid, bus.in_ready, bus.err_out, bus.diff_out},
             {22'd0, 1'b1, 1'b0, 1'b0, 8'hFF});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("bp_release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
      ok = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.out_valid || !bus.in_ready) ok = 1'b0;
      end
      chk("bp_no_new_job", {31'd0, ok}, 32'd1);

      // Random adder-model pairs: p = a + b must split back to a with no error.
      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rp = {1'b0, ra} + {1'b0, rb};
         do_job(rp, rb, ra, 1'b0, $urandom_range(0, 3), $sformatf("rand%0d", n));
      end
      // Random p < b pairs must flag an error.
      for (int n = 0; n < 100; n++) begin
         rb = 8'($urandom_range(1, 255));
         rp = 9'($urandom_range(0, int'(rb) - 1));
         t9 = rp - {1'b0, rb};
         do_job(rp, rb, t9[7:0], 1'b1, $urandom_range(0, 3), $sformatf("rand_err%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
